// File: rtl/serial_sub8_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and the full-adder constants used to turn an adder into a subtractor.
package serial_sub8_pkg;

  // Operand/result width used when the parent does not override it.
  localparam int unsigned DefaultWidth = 8;

  // Carry-in that makes a + ~b + carry equal a - b when there is no borrow-in.
  localparam logic SubCarryNoBorrow = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/fulladder.sv
// One-bit full-adder cell.
module fulladder (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first,
// through a single full-adder cell with the subtrahend bit inverted.
module serial_sub8
  import serial_sub8_pkg::*;
#(
  parameter int unsigned n = DefaultWidth
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  // Counter holds 0..n inclusive, so it never wraps within one operation.
  localparam int unsigned CntW = $clog2(n + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(n - 1);

  state_e          state_q;
  logic [n-1:0]    a_sh_q;
  logic [n-1:0]    b_sh_q;
  logic [n-1:0]    res_sh_q;
  logic [n-1:0]    diff_q;
  logic [CntW-1:0] cnt_q;
  logic            carry_q;
  logic            busy_q;
  logic            done_q;
  logic            bout_q;
  logic            ovf_q;

  logic            b_inv;
  logic            fa_sum;
  logic            fa_cout;
  logic [n-1:0]    res_next;

  assign b_inv = ~b_sh_q[0];

  fulladder u_fa (
    .sum  (fa_sum),
    .cout (fa_cout),
    .a    (a_sh_q[0]),
    .b    (b_inv),
    .cin  (carry_q)
  );

  // Result register after shifting in the current sum bit at the MSB.
  always_comb begin
    res_next = {fa_sum, res_sh_q[n-1:1]};
  end

  // FSM, operand/result shift registers, bit counter and registered outputs.
  // diff is a shadow of the shift register, updated only on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= SubCarryNoBorrow ^ bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          res_sh_q <= res_next;
          carry_q  <= fa_cout;
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            // Bit 0 of the operand shifters is now the captured MSB.
            diff_q  <= res_next;
            bout_q  <= ~fa_cout;
            ovf_q   <= (a_sh_q[0] != b_sh_q[0]) && (fa_sum != a_sh_q[0]);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub8.sv
// Scoreboard bench for serial_sub8: stimulus pushes expected results, a
// negedge monitor pops and compares whenever done is presented.
module tb_serial_sub8;

  localparam int unsigned N = 8;

  typedef struct {
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;
    int           acc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         op_bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   last_done = -1;
  bit   sweep_on = 0;
  bit   have_held = 0;
  logic [N-1:0] held_diff;

  serial_sub8 #(.n(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (op_a),
    .b     (op_b),
    .bin   (op_bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                 input logic mbin);
    exp_t   e;
    longint ua, ub, sa, sb_, d, sd, lo, hi;
    ua = ma;
    ub = mb;
    sa = $signed(ma);
    sb_ = $signed(mb);
    d  = ua - ub - longint'(mbin);
    sd = sa - sb_ - longint'(mbin);
    lo = -(longint'(1) << (N - 1));
    hi = (longint'(1) << (N - 1)) - 1;
    e.diff = d[N-1:0];
    e.bout = (ua < ub + longint'(mbin));
    e.ovf  = (sd < lo) || (sd > hi);
    e.acc  = 0;
    return e;
  endfunction

  // Monitor: compares on every done, checks exclusivity, latency, spacing, hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      have_held = 0;
    end else begin
      if (busy && done) check("busy_done_exclusive", 1, 0);
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("diff", diff, e.diff);
          check("bout", bout, e.bout);
          check("ovf", ovf, e.ovf);
          check("latency", cyc - e.acc, N);
        end
        if (sweep_on && last_done >= 0) check("done_spacing", cyc - last_done, N + 2);
        last_done = cyc;
        held_diff = diff;
        have_held = 1;
      end else if (!busy && have_held) begin
        if (diff !== held_diff) check("diff_held", diff, held_diff);
      end else if (busy) begin
        if (have_held && diff !== held_diff) check("diff_no_partial", diff, held_diff);
      end
    end
  end

  task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tbin);
    exp_t e;
    @(negedge clk);
    op_a = ta;
    op_b = tb_v;
    op_bin = tbin;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    e = model(ta, tb_v, tbin);
    e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 4 * N + 20; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("wait_idle_timeout", 0, 1);
      sb.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    bit ok;
    exp_t e;
    rst_n = 1'b0;
    start = 1'b0;
    op_a = '0;
    op_b = '0;
    op_bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    issue(8'h05, 8'h03, 1'b0); wait_idle();
    issue(8'h03, 8'h05, 1'b0); wait_idle();
    issue(8'h80, 8'h01, 1'b0); wait_idle();
    issue(8'h00, 8'h00, 1'b1); wait_idle();
    issue(8'h7F, 8'hFF, 1'b0); wait_idle();

    // start re-pulsed during RUN must be ignored.
    dc = done_cnt;
    issue(8'h05, 8'h03, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    op_a = 8'hFF;
    op_b = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (N + 4) @(negedge clk);
    check("single_done_on_restart", done_cnt - dc, 1);

    // Reset mid-RUN aborts with no done pulse.
    issue(8'h33, 8'h11, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
    check("abort_ovf", ovf, 0);
    sb.delete();
    dc = done_cnt;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2 * N) @(negedge clk);
    check("no_done_after_abort", done_cnt - dc, 0);
    issue(8'h10, 8'h01, 1'b0); wait_idle();

    // Random sweep with start held high.
    sweep_on = 1;
    last_done = -1;
    op_a = N'($urandom);
    op_b = N'($urandom);
    op_bin = 1'($urandom);
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      ok = 0;
      for (int i = 0; i < 2 * N + 10; i++) begin
        @(posedge clk);
        #1;
        if (busy) begin
          ok = 1;
          break;
        end
      end
      if (!ok) begin
        check("sweep_accept_timeout", 0, 1);
        break;
      end
      e = model(op_a, op_b, op_bin);
      e.acc = cyc;
      sb.push_back(e);
      op_a = N'($urandom);
      op_b = N'($urandom);
      op_bin = 1'($urandom);
      ok = 0;
      for (int i = 0; i < 2 * N + 10; i++) begin
        @(posedge clk);
        #1;
        if (!busy) begin
          ok = 1;
          break;
        end
      end
      if (!ok) begin
        check("sweep_run_timeout", 0, 1);
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    sweep_on = 0;
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
